pipe_hazard_ctrl: RTL and testbench

//  Hazard controller for the 5-stage MIPS pipeline (IF/ID/EX/MEM/WB). A 3-entry scoreboard

---
 rtl/pipe_ctrl_pkg.sv | 36 +++
 rtl/pipe_hazard_ctrl_if.sv | 49 ++++
 rtl/hazard_scoreboard.sv | 52 +++++
 rtl/pipe_hazard_ctrl.sv | 118 +++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 375 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and helpers for the pipeline hazard controller
// Contents:
//   state_t     controller action taken last cycle (RUN/STALL/FLUSH)
//   sb_entry_t  scoreboard entry {v, rd}; an entry naming $0 is never valid
//   REG_ZERO    architectural $0
//   SB_INVALID  empty scoreboard entry
//   sb_make     builds an entry, forcing v=0 for $0 destinations
//   sb_hit      true when an entry is valid and names the given register
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      STALL = 2'd1,
      FLUSH = 2'd2
   } state_t;

   typedef struct packed {
      logic       v;
      logic [4:0] rd;
   } sb_entry_t;

   localparam logic [4:0] REG_ZERO   = 5'd0;
   localparam sb_entry_t  SB_INVALID = '{v: 1'b0, rd: REG_ZERO};

   function automatic sb_entry_t sb_make(input logic v, input logic [4:0] r);
      sb_entry_t e;
      e.v  = v & (r != REG_ZERO);
      e.rd = r;
      return e;
   endfunction

   function automatic logic sb_hit(input sb_entry_t e, input logic [4:0] r);
      return e.v && (e.rd == r);
   endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - ID/MEM status in, pipeline control out
// Signals:
//   ID slot  : id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wr_en, id_wr_reg
//   MEM slot : mem_br_taken
//   control  : pc_hold, ifid_hold, idex_bubble, flush_ifid, flush_idex, flush_exmem
//   status   : state, stall_err, stall_cnt, flush_cnt
// Modports:
//   master   datapath side (drives ID/MEM status, receives control)
//   slave    hazard controller side
interface pipe_hazard_ctrl_if #(
   parameter int CNT_W = 16
);
   import pipe_ctrl_pkg::*;

   logic             id_valid;
   logic [4:0]       id_rs;
   logic [4:0]       id_rt;
   logic             id_use_rs;
   logic             id_use_rt;
   logic             id_wr_en;
   logic [4:0]       id_wr_reg;
   logic             mem_br_taken;

   logic             pc_hold;
   logic             ifid_hold;
   logic             idex_bubble;
   logic             flush_ifid;
   logic             flush_idex;
   logic             flush_exmem;
   state_t           state;
   logic             stall_err;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   modport master (
      output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wr_en, id_wr_reg,
             mem_br_taken,
      input  pc_hold, ifid_hold, idex_bubble, flush_ifid, flush_idex, flush_exmem,
             state, stall_err, stall_cnt, flush_cnt
   );

   modport slave (
      input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wr_en, id_wr_reg,
             mem_br_taken,
      output pc_hold, ifid_hold, idex_bubble, flush_ifid, flush_idex, flush_exmem,
             state, stall_err, stall_cnt, flush_cnt
   );

endinterface

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - 3-entry in-flight destination tracker (EX/MEM/WB)
// Ports:
//   clock, reset_n  negedge clock, async active-low reset
//   i_kill_ex       load an invalid entry into EX (bubble, stall or flush)
//   i_kill_mem      invalidate the entry moving EX->MEM (taken-branch flush)
//   i_wr_en         ID instruction writes a register
//   i_wr_reg        ID destination register
//   i_rs, i_rt      ID source registers to look up
//   o_match_rs/rt   source register is written by an in-flight instruction
module hazard_scoreboard
   import pipe_ctrl_pkg::*;
#(
   parameter bit WB_HAZARD = 1'b1
)
(
   input  logic       clock,
   input  logic       reset_n,
   input  logic       i_kill_ex,
   input  logic       i_kill_mem,
   input  logic       i_wr_en,
   input  logic [4:0] i_wr_reg,
   input  logic [4:0] i_rs,
   input  logic [4:0] i_rt,
   output logic       o_match_rs,
   output logic       o_match_rt
);

   sb_entry_t r_sb_ex;
   sb_entry_t r_sb_mem;
   sb_entry_t r_sb_wb;

   // Entries shift along with the datapath on the same edge it uses.
   always_ff @(negedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_sb_ex  <= SB_INVALID;
         r_sb_mem <= SB_INVALID;
         r_sb_wb  <= SB_INVALID;
      end else begin
         r_sb_wb  <= r_sb_mem;
         r_sb_mem <= i_kill_mem ? SB_INVALID : r_sb_ex;
         r_sb_ex  <= i_kill_ex  ? SB_INVALID : sb_make(i_wr_en, i_wr_reg);
      end
   end

   // The regfile is written on the same edge ID reads it, so a WB writer
   // still counts as a hazard unless the regfile forwards internally.
   assign o_match_rs = sb_hit(r_sb_ex, i_rs) | sb_hit(r_sb_mem, i_rs)
                     | (WB_HAZARD & sb_hit(r_sb_wb, i_rs));
   assign o_match_rt = sb_hit(r_sb_ex, i_rt) | sb_hit(r_sb_mem, i_rt)
                     | (WB_HAZARD & sb_hit(r_sb_wb, i_rt));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - RAW stall and taken-branch flush control for a 5-stage pipeline
// Ports:
//   clock    pipeline clock; state updates on negedge like the datapath
//   reset_n  asynchronous active-low reset
//   bus      pipe_hazard_ctrl_if.slave (ID/MEM status in, hold/bubble/flush out,
//            state, sticky stall_err, saturating stall_cnt/flush_cnt)
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter bit WB_HAZARD = 1'b1,
   parameter int MAX_STALL = 3,
   parameter int CNT_W     = 16
)
(
   input  logic                clock,
   input  logic                reset_n,
   pipe_hazard_ctrl_if.slave   bus
);

   localparam int               RUN_W   = (MAX_STALL < 1) ? 1 : $clog2(MAX_STALL + 1);
   localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_STALL);

   logic             w_match_rs;
   logic             w_match_rt;
   logic             w_haz;
   logic             w_flush;
   logic             w_stall;
   state_t           w_state_next;

   state_t           r_state;
   logic [RUN_W-1:0] r_run;
   logic             r_stall_err;
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;

   hazard_scoreboard #(
      .WB_HAZARD (WB_HAZARD)
   ) u_sb (
      .clock      (clock),
      .reset_n    (reset_n),
      .i_kill_ex  (w_flush | w_haz | ~bus.id_valid),
      .i_kill_mem (w_flush),
      .i_wr_en    (bus.id_wr_en),
      .i_wr_reg   (bus.id_wr_reg),
      .i_rs       (bus.id_rs),
      .i_rt       (bus.id_rt),
      .o_match_rs (w_match_rs),
      .o_match_rt (w_match_rt)
   );

   assign w_haz = bus.id_valid &
                  ((bus.id_use_rs & (bus.id_rs != REG_ZERO) & w_match_rs) |
                   (bus.id_use_rt & (bus.id_rt != REG_ZERO) & w_match_rt));
   assign w_flush = bus.mem_br_taken;
   // A taken branch squashes the stalled ID instruction, so the stall is dropped.
   assign w_stall = w_haz & ~w_flush;

   // Control outputs are forced low while reset is asserted.
   assign bus.pc_hold     = reset_n & w_stall;
   assign bus.ifid_hold   = reset_n & w_stall;
   assign bus.idex_bubble = reset_n & w_stall;
   assign bus.flush_ifid  = reset_n & w_flush;
   assign bus.flush_idex  = reset_n & w_flush;
   assign bus.flush_exmem = reset_n & w_flush;

   assign bus.state     = r_state;
   assign bus.stall_err = r_stall_err;
   assign bus.stall_cnt = r_stall_cnt;
   assign bus.flush_cnt = r_flush_cnt;

   always_comb begin
      w_state_next = RUN;
      if (w_flush) begin
         w_state_next = FLUSH;
      end else if (w_haz) begin
         w_state_next = STALL;
      end
   end

   always_ff @(negedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= RUN;
      end else begin
         r_state <= w_state_next;
      end
   end

   // r_run saturates at MAX_STALL; one more stall cycle from there is the error.
   always_ff @(negedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_run       <= '0;
         r_stall_err <= 1'b0;
      end else if (w_stall) begin
         if (r_run == RUN_MAX) begin
            r_stall_err <= 1'b1;
         end else begin
            r_run <= r_run + RUN_W'(1);
         end
      end else begin
         r_run <= '0;
      end
   end

   always_ff @(negedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (w_stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         end
         if (w_flush && (r_flush_cnt != '1)) begin
            r_flush_cnt <= r_flush_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed bench for pipe_hazard_ctrl
// u0: WB_HAZARD=1 MAX_STALL=3 CNT_W=16; u1: WB_HAZARD=0; u2: CNT_W=4 MAX_STALL=2.
// All three see the same ID/MEM stimulus.
module tb_pipe_hazard_ctrl;
   import pipe_ctrl_pkg::*;

   logic       clock;
   logic       reset_n;
   logic       t_valid;
   logic [4:0] t_rs;
   logic [4:0] t_rt;
   logic       t_use_rs;
   logic       t_use_rt;
   logic       t_wr_en;
   logic [4:0] t_wr_reg;
   logic       t_br;

   int n_checks = 0;
   int n_fail   = 0;
   int exp_s0   = 0;
   int exp_s1   = 0;

   pipe_hazard_ctrl_if #(.CNT_W(16)) if0 ();
   pipe_hazard_ctrl_if #(.CNT_W(16)) if1 ();
   pipe_hazard_ctrl_if #(.CNT_W(4))  if2 ();

   assign if0.id_valid = t_valid;   assign if1.id_valid = t_valid;   assign if2.id_valid = t_valid;
   assign if0.id_rs = t_rs;         assign if1.id_rs = t_rs;         assign if2.id_rs = t_rs;
   assign if0.id_rt = t_rt;         assign if1.id_rt = t_rt;         assign if2.id_rt = t_rt;
   assign if0.id_use_rs = t_use_rs; assign if1.id_use_rs = t_use_rs; assign if2.id_use_rs = t_use_rs;
   assign if0.id_use_rt = t_use_rt; assign if1.id_use_rt = t_use_rt; assign if2.id_use_rt = t_use_rt;
   assign if0.id_wr_en = t_wr_en;   assign if1.id_wr_en = t_wr_en;   assign if2.id_wr_en = t_wr_en;
   assign if0.id_wr_reg = t_wr_reg; assign if1.id_wr_reg = t_wr_reg; assign if2.id_wr_reg = t_wr_reg;
   assign if0.mem_br_taken = t_br;  assign if1.mem_br_taken = t_br;  assign if2.mem_br_taken = t_br;

   pipe_hazard_ctrl #(.WB_HAZARD(1'b1), .MAX_STALL(3), .CNT_W(16)) u0 (
      .clock(clock), .reset_n(reset_n), .bus(if0.slave));
   pipe_hazard_ctrl #(.WB_HAZARD(1'b0), .MAX_STALL(3), .CNT_W(16)) u1 (
      .clock(clock), .reset_n(reset_n), .bus(if1.slave));
   pipe_hazard_ctrl #(.WB_HAZARD(1'b1), .MAX_STALL(2), .CNT_W(4)) u2 (
      .clock(clock), .reset_n(reset_n), .bus(if2.slave));

   initial begin
      clock = 1'b1;
      forever #5 clock = ~clock;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, summary not printed");
      $fatal(1);
   end

   task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic urs, input logic urt, input logic we,
                         input logic [4:0] wr);
      t_valid = v; t_rs = rs; t_rt = rt; t_use_rs = urs; t_use_rt = urt;
      t_wr_en = we; t_wr_reg = wr;
   endtask

   task automatic to_mid();
      @(posedge clock); #1;
   endtask

   task automatic to_next();
      @(negedge clock); #1;
   endtask

   task automatic drain();
      set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0);
      t_br = 1'b0;
      repeat (3) to_next();
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      t_br = 1'b1;
      set_id(1'b1, 5'd9, 5'd9, 1'b1, 1'b1, 1'b1, 5'd9);
      #2;
      n_checks++;
      if ({if0.pc_hold, if0.ifid_hold, if0.idex_bubble,
           if0.flush_ifid, if0.flush_idex, if0.flush_exmem} !== 6'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl_outs got %b want 000000", {if0.pc_hold, if0.ifid_hold,
                  if0.idex_bubble, if0.flush_ifid, if0.flush_idex, if0.flush_exmem});
      end
      n_checks++;
      if (if0.state !== RUN || if0.stall_err !== 1'b0 || if0.stall_cnt !== 16'd0
          || if0.flush_cnt !== 16'd0) begin
         n_fail++;
         $display("FAIL reset_status got state=%0d err=%0b sc=%0d fc=%0d want 0 0 0 0",
                  if0.state, if0.stall_err, if0.stall_cnt, if0.flush_cnt);
      end
      t_br = 1'b0;
      set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0);
      to_next();
      reset_n = 1'b1;
   endtask

   // lw $t1,0($0) ; slt $t3,$t1,$t2 back to back
   task automatic test_raw_lw_slt();
      int c0 = 0;
      int c1 = 0;
      set_id(1'b1, 5'd0, 5'd9, 1'b1, 1'b0, 1'b1, 5'd9);
      to_mid();
      n_checks++;
      if (if0.pc_hold !== 1'b0) begin
         n_fail++;
         $display("FAIL lw_no_stall pc_hold got %b want 0", if0.pc_hold);
      end
      to_next();
      set_id(1'b1, 5'd9, 5'd10, 1'b1, 1'b1, 1'b1, 5'd11);
      for (int i = 0; i < 4; i++) begin
         if (i == 3) set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0);
         to_mid();
         c0 += int'(if0.pc_hold);
         c1 += int'(if1.pc_hold);
         if (i == 0) begin
            n_checks++;
            if (if0.ifid_hold !== 1'b1 || if0.idex_bubble !== 1'b1) begin
               n_fail++;
               $display("FAIL slt_hold_bubble got %b%b want 11", if0.ifid_hold, if0.idex_bubble);
            end
         end
         to_next();
         if (i == 0) begin
            n_checks++;
            if (if0.state !== STALL) begin
               n_fail++;
               $display("FAIL slt_state_stall got %0d want 1", if0.state);
            end
         end
         if (i == 1) begin
            n_checks++;
            if (if2.stall_err !== 1'b0) begin
               n_fail++;
               $display("FAIL err_after_2 got %b want 0", if2.stall_err);
            end
         end
         if (i == 2) begin
            n_checks++;
            if (if2.stall_err !== 1'b1 || if0.stall_err !== 1'b0) begin
               n_fail++;
               $display("FAIL err_after_3 got u2=%b u0=%b want 1 0", if2.stall_err, if0.stall_err);
            end
         end
      end
      exp_s0 += 3;
      exp_s1 += 2;
      n_checks++;
      if (c0 != 3) begin
         n_fail++;
         $display("FAIL raw_stall_cycles_wb1 got %0d want 3", c0);
      end
      n_checks++;
      if (c1 != 2) begin
         n_fail++;
         $display("FAIL raw_stall_cycles_wb0 got %0d want 2", c1);
      end
      n_checks++;
      if (if0.stall_cnt !== 16'(exp_s0) || if1.stall_cnt !== 16'(exp_s1)
          || if2.stall_cnt !== 4'd3) begin
         n_fail++;
         $display("FAIL raw_stall_cnt got %0d %0d %0d want %0d %0d 3",
                  if0.stall_cnt, if1.stall_cnt, if2.stall_cnt, exp_s0, exp_s1);
      end
      n_checks++;
      if (if0.state !== RUN) begin
         n_fail++;
         $display("FAIL raw_state_run got %0d want 0", if0.state);
      end
      drain();
   endtask

   // {v, rs, rt, use_rs, use_rt, wr_en, wr_reg}; none of these may stall
   task automatic test_zero_reg_independent();
      logic [18:0] seq [0:6] = '{
         {1'b1, 5'd9,  5'd10, 1'b1, 1'b1, 1'b1, 5'd0 },  // add $0,$t1,$t2
         {1'b1, 5'd0,  5'd0,  1'b1, 1'b1, 1'b1, 5'd11},  // add $t3,$0,$0
         {1'b1, 5'd13, 5'd12, 1'b1, 1'b1, 1'b0, 5'd12},  // sw $12,0($13)
         {1'b1, 5'd12, 5'd0,  1'b1, 1'b1, 1'b1, 5'd14},  // add $14,$12,$0
         {1'b1, 5'd13, 5'd14, 1'b1, 1'b0, 1'b1, 5'd14},  // addi $14,$13,imm
         {1'b1, 5'd9,  5'd10, 1'b1, 1'b1, 1'b1, 5'd17},  // add $17,$t1,$t2
         {1'b0, 5'd17, 5'd17, 1'b1, 1'b1, 1'b1, 5'd18}   // empty slot
      };
      for (int i = 0; i < 7; i++) begin
         set_id(seq[i][18], seq[i][17:13], seq[i][12:8], seq[i][7], seq[i][6],
                seq[i][5], seq[i][4:0]);
         to_mid();
         n_checks++;
         if (if0.pc_hold !== 1'b0) begin
            n_fail++;
            $display("FAIL no_stall_seq[%0d] pc_hold got %b want 0", i, if0.pc_hold);
         end
         to_next();
      end
      n_checks++;
      if (if0.stall_cnt !== 16'(exp_s0)) begin
         n_fail++;
         $display("FAIL indep_stall_cnt got %0d want %0d", if0.stall_cnt, exp_s0);
      end
      n_checks++;
      if (if2.stall_err !== 1'b1) begin
         n_fail++;
         $display("FAIL err_sticky got %b want 1", if2.stall_err);
      end
      drain();
   endtask

   task automatic test_branch_flush();
      set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd20);
      to_next();
      set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd21);
      t_br = 1'b1;
      to_mid();
      n_checks++;
      if ({if0.flush_ifid, if0.flush_idex, if0.flush_exmem, if0.pc_hold} !== 4'b1110) begin
         n_fail++;
         $display("FAIL br_flush_outs got %b want 1110",
                  {if0.flush_ifid, if0.flush_idex, if0.flush_exmem, if0.pc_hold});
      end
      to_next();
      n_checks++;
      if (if0.state !== FLUSH || if0.flush_cnt !== 16'd1) begin
         n_fail++;
         $display("FAIL br_state_cnt got state=%0d fc=%0d want 2 1", if0.state, if0.flush_cnt);
      end
      t_br = 1'b0;
      set_id(1'b1, 5'd20, 5'd21, 1'b1, 1'b1, 1'b1, 5'd22);
      to_mid();
      n_checks++;
      if (if0.flush_ifid !== 1'b0 || if0.pc_hold !== 1'b0) begin
         n_fail++;
         $display("FAIL br_after got flush=%b pc_hold=%b want 0 0", if0.flush_ifid, if0.pc_hold);
      end
      to_next();
      n_checks++;
      if (if0.state !== RUN || if0.flush_cnt !== 16'd1) begin
         n_fail++;
         $display("FAIL br_one_cycle got state=%0d fc=%0d want 0 1", if0.state, if0.flush_cnt);
      end
      drain();
   endtask

   task automatic test_branch_during_stall();
      set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd8);
      to_next();
      set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd9);
      to_next();
      set_id(1'b1, 5'd9, 5'd10, 1'b1, 1'b1, 1'b1, 5'd11);
      t_br = 1'b1;
      to_mid();
      n_checks++;
      if ({if0.pc_hold, if0.ifid_hold, if0.idex_bubble, if0.flush_idex} !== 4'b0001) begin
         n_fail++;
         $display("FAIL brstall_outs got %b want 0001",
                  {if0.pc_hold, if0.ifid_hold, if0.idex_bubble, if0.flush_idex});
      end
      to_next();
      n_checks++;
      if (if0.state !== FLUSH || if0.stall_cnt !== 16'(exp_s0) || if0.flush_cnt !== 16'd2) begin
         n_fail++;
         $display("FAIL brstall_status got state=%0d sc=%0d fc=%0d want 2 %0d 2",
                  if0.state, if0.stall_cnt, if0.flush_cnt, exp_s0);
      end
      t_br = 1'b0;
      set_id(1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 5'd11);
      to_mid();
      n_checks++;
      if (if0.pc_hold !== 1'b0) begin
         n_fail++;
         $display("FAIL brstall_ex_mem_cleared pc_hold got %b want 0", if0.pc_hold);
      end
      // $8 was older than the branch and sits in WB, so it still blocks
      set_id(1'b1, 5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 5'd12);
      #1;
      n_checks++;
      if (if0.pc_hold !== 1'b1 || if1.pc_hold !== 1'b0) begin
         n_fail++;
         $display("FAIL brstall_wb_kept got u0=%b u1=%b want 1 0", if0.pc_hold, if1.pc_hold);
      end
      set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0);
      to_next();
      drain();
   endtask

   task automatic test_reset_mid_stall();
      set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd9);
      to_next();
      set_id(1'b1, 5'd9, 5'd10, 1'b1, 1'b1, 1'b1, 5'd11);
      to_next();
      to_mid();
      n_checks++;
      if (if0.pc_hold !== 1'b1 || if0.state !== STALL) begin
         n_fail++;
         $display("FAIL pre_reset_stall got pc_hold=%b state=%0d want 1 1", if0.pc_hold, if0.state);
      end
      reset_n = 1'b0;
      t_br = 1'b1;
      #1;
      n_checks++;
      if ({if0.pc_hold, if0.ifid_hold, if0.idex_bubble,
           if0.flush_ifid, if0.flush_idex, if0.flush_exmem} !== 6'b0) begin
         n_fail++;
         $display("FAIL midreset_outs got %b want 000000", {if0.pc_hold, if0.ifid_hold,
                  if0.idex_bubble, if0.flush_ifid, if0.flush_idex, if0.flush_exmem});
      end
      n_checks++;
      if (if0.state !== RUN || if0.stall_cnt !== 16'd0 || if0.flush_cnt !== 16'd0
          || if2.stall_err !== 1'b0) begin
         n_fail++;
         $display("FAIL midreset_status got state=%0d sc=%0d fc=%0d err=%b want 0 0 0 0",
                  if0.state, if0.stall_cnt, if0.flush_cnt, if2.stall_err);
      end
      exp_s0 = 0;
      exp_s1 = 0;
      t_br = 1'b0;
      to_next();
      reset_n = 1'b1;
      to_mid();
      n_checks++;
      if (if0.pc_hold !== 1'b0) begin
         n_fail++;
         $display("FAIL post_reset_empty_sb pc_hold got %b want 0", if0.pc_hold);
      end
      to_next();
      drain();
   endtask

   task automatic test_saturate();
      for (int p = 0; p < 6; p++) begin
         set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd9);
         to_next();
         set_id(1'b1, 5'd9, 5'd10, 1'b1, 1'b1, 1'b1, 5'd11);
         repeat (3) to_next();
         exp_s0 += 3;
         if (p == 4) begin
            n_checks++;
            if (if2.stall_cnt !== 4'd15 || if0.stall_cnt !== 16'd15) begin
               n_fail++;
               $display("FAIL sat_reach got u2=%0d u0=%0d want 15 15", if2.stall_cnt, if0.stall_cnt);
            end
         end
      end
      n_checks++;
      if (if2.stall_cnt !== 4'd15) begin
         n_fail++;
         $display("FAIL sat_hold got %0d want 15", if2.stall_cnt);
      end
      n_checks++;
      if (if0.stall_cnt !== 16'(exp_s0)) begin
         n_fail++;
         $display("FAIL sat_wide got %0d want %0d", if0.stall_cnt, exp_s0);
      end
      n_checks++;
      if (if2.stall_err !== 1'b1 || if0.stall_err !== 1'b0) begin
         n_fail++;
         $display("FAIL sat_err got u2=%b u0=%b want 1 0", if2.stall_err, if0.stall_err);
      end
      drain();
   endtask

   initial begin
      test_reset();
      test_raw_lw_slt();
      test_zero_reg_independent();
      test_branch_flush();
      test_branch_during_stall();
      test_reset_mid_stall();
      test_saturate();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
